fetch_sequencer: RTL

Controller that sequences the instruction-fetch datapath: owns the PC, issues one-at-a-time requests to instruction memory over a req/ack handshake, and buffers up to two returned instructions for decode behind a valid/ready handshake. Applies branch redirects (`pcSrc`/`branchAddr`) and discards stale in-flight fetches. It sits between instruction memory and the decode stage and replaces the free-running PC update in the fetch stage.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_sequencer_if.sv | 37 +++
 rtl/fetch_fifo2.sv | 54 +++++
 rtl/fetch_sequencer.sv | 97 +++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: widths, FSM encoding,
// FIFO entry layout and the PC increment helper.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_inc(
    input logic [XLEN-1:0] pc
  );
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory req/ack bus plus the decode-side valid/ready bus
// of the fetch sequencer.
interface fetch_sequencer_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instruction;
  logic [XLEN-1:0] adderOutput;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output instr_valid,
    input  instr_ready,
    output instruction,
    output adderOutput
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  instr_valid,
    output instr_ready,
    input  instruction,
    input  adderOutput
  );

endinterface

// File: rtl/fetch_fifo2.sv
// Two-entry FIFO of {instruction, pc+4}; pop is applied before flush
// and flush overrides push.
module fetch_fifo2
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);

  fetch_entry_t r_mem [2];
  logic         r_rd;
  logic         r_wr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign w_push = i_push && !i_flush;
  assign w_pop  = i_pop && (r_count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push)
        r_wr <= ~r_wr;
      if (w_pop)
        r_rd <= ~r_rd;
      r_count <= r_count
               + {1'b0, w_push}
               - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr] <= i_data;
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues one request at a time to
// instruction memory and buffers up to two instructions for decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pcSrc,
  input  logic [XLEN-1:0]   branchAddr,
  fetch_sequencer_if.master fbus
);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_pc4;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_count;
  logic [1:0]      w_count_nxt;
  logic            w_room;
  fetch_entry_t    w_entry;
  fetch_entry_t    w_head;

  assign w_pc4  = pc_inc(r_pc);
  assign w_pop  = fbus.instr_valid && fbus.instr_ready;
  assign w_push = (r_state == ST_REQ)
               && fbus.imem_ack && !pcSrc;

  // a request only issues when the next-cycle occupancy leaves a slot
  assign w_count_nxt = w_count
                     + {1'b0, w_push}
                     - {1'b0, w_pop};
  assign w_room      = (w_count_nxt < 2'd2);

  assign w_entry.instr = fbus.imem_rdata;
  assign w_entry.pc4   = w_pc4;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    unique case (1'b1)
      (r_state == ST_IDLE): begin
        if (pcSrc || w_room)
          w_state_nxt = ST_REQ;
      end
      (r_state == ST_REQ): begin
        if (pcSrc) begin
          w_state_nxt = fbus.imem_ack
                      ? ST_REQ : ST_FLUSH;
        end else if (fbus.imem_ack) begin
          w_pc_nxt    = w_pc4;
          w_state_nxt = w_room
                      ? ST_REQ : ST_IDLE;
        end
      end
      (r_state == ST_FLUSH): begin
        if (fbus.imem_ack)
          w_state_nxt = ST_REQ;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (pcSrc)
      w_pc_nxt = branchAddr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  fetch_fifo2 u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (pcSrc),
    .i_data  (w_entry),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign fbus.imem_req    = (r_state == ST_REQ);
  assign fbus.imem_addr   = r_pc;
  assign fbus.instr_valid = (w_count != 2'd0);
  assign fbus.instruction = w_head.instr;
  assign fbus.adderOutput = w_head.pc4;

endmodule
